// File: rtl/switch_pkt_tx.sv
// Packet transmitter: payload FIFO plus DA/SA/LEN/payload serializer with a forced idle gap.
// Latency: start accepted at edge N, DA byte on data after edge N+1; writes are dropped unless idle and not full.
module switch_pkt_tx #(
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       wr_drop,
  input  logic       start,
  input  logic [7:0] dest_addr,
  input  logic [7:0] src_addr,
  output logic       busy,
  output logic       done,
  output logic [7:0] data,
  output logic       data_status
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_DA, S_SA, S_LEN, S_PAY, S_GAP} state_t;

  state_t          state_q;
  logic [7:0]      mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d, len_q, rem_q;
  logic [GW-1:0]   gap_q;
  logic [7:0]      da_q, sa_q, data_q;
  logic            full_q, empty_q, drop_q, busy_q, done_q, status_q;
  logic            accept, push, pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // busy_q gates acceptance so a new packet never starts in a cycle that still reports busy
  always_comb begin
    accept  = (state_q == S_IDLE) && !busy_q && start && !empty_q;
    push    = wr_en && (state_q == S_IDLE) && !full_q && !accept;
    pop     = (state_q == S_PAY);
    count_d = count_q;
    if (push)     count_d = count_q + 1'b1;
    else if (pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      len_q    <= '0;
      rem_q    <= '0;
      gap_q    <= '0;
      da_q     <= '0;
      sa_q     <= '0;
      data_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      drop_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      status_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
      count_q  <= count_d;
      full_q   <= (count_d == CW'(DEPTH));
      empty_q  <= (count_d == '0);
      drop_q   <= wr_en && !push;
      done_q   <= 1'b0;
      data_q   <= '0;
      status_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          if (accept) begin
            da_q    <= dest_addr;
            sa_q    <= src_addr;
            len_q   <= count_q;
            state_q <= S_DA;
          end
        end
        S_DA: begin
          busy_q   <= 1'b1;
          data_q   <= da_q;
          status_q <= 1'b1;
          state_q  <= S_SA;
        end
        S_SA: begin
          data_q   <= sa_q;
          status_q <= 1'b1;
          state_q  <= S_LEN;
        end
        S_LEN: begin
          data_q   <= 8'(len_q);
          status_q <= 1'b1;
          rem_q    <= len_q;
          state_q  <= S_PAY;
        end
        S_PAY: begin
          data_q   <= mem_q[rd_ptr_q];
          status_q <= 1'b1;
          rem_q    <= rem_q - 1'b1;
          if (rem_q == CW'(1)) begin
            gap_q   <= '0;
            state_q <= S_GAP;
          end
        end
        S_GAP: begin
          done_q <= (gap_q == '0);
          gap_q  <= gap_q + 1'b1;
          if (gap_q == GW'(GAP_CYCLES - 1)) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign full        = full_q;
  assign empty       = empty_q;
  assign wr_drop     = drop_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign data        = data_q;
  assign data_status = status_q;

endmodule

// File: tb/tb_switch_pkt_tx.sv
// Scoreboard bench for switch_pkt_tx: host-level FIFO model feeds an expected byte stream checked by a monitor.
module tb_switch_pkt_tx;
  localparam int DEPTH = 16;
  localparam int GAP   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0, start = 1'b0;
  logic [7:0] wr_data = '0, dest_addr = '0, src_addr = '0;
  logic       full, empty, wr_drop, busy, done, data_status;
  logic [7:0] data;

  switch_pkt_tx #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full), .empty(empty),
    .wr_drop(wr_drop), .start(start), .dest_addr(dest_addr), .src_addr(src_addr),
    .busy(busy), .done(done), .data(data), .data_status(data_status)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] b; bit last; } exp_t;
  exp_t       exp_q[$];
  logic [7:0] model_q[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every packet byte must match the scoreboard, packets contiguous, done and gap after each.
  initial begin : monitor
    bit   in_pkt = 0;
    bit   done_due = 0;
    int   gap_left = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        in_pkt = 0; done_due = 0; gap_left = 0;
        continue;
      end
      chk("done", done, done_due);
      done_due = 0;
      if (data_status) begin
        if (gap_left > 0) chk("gap_too_short", gap_left, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", data_status, 0);
        end else begin
          e = exp_q.pop_front();
          chk("stream_byte", data, e.b);
          in_pkt = !e.last;
          if (e.last) begin
            done_due = 1;
            gap_left = GAP;
          end
        end
      end else begin
        chk("idle_data_zero", data, 0);
        if (in_pkt) chk("stream_broken", data_status, 1);
        in_pkt = 0;
        if (gap_left > 0) begin
          chk("gap_busy", busy, 1);
          gap_left--;
        end
      end
    end
  end

  // All host tasks are entered and left on a falling edge.
  task automatic write_byte(input logic [7:0] d);
    bit exp_drop = (model_q.size() >= DEPTH);
    wr_en = 1'b1; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (!exp_drop) model_q.push_back(d);
    chk("wr_drop", wr_drop, exp_drop);
    chk("full", full, model_q.size() == DEPTH);
    chk("empty", empty, model_q.size() == 0);
  endtask

  task automatic do_start(input logic [7:0] da, input logic [7:0] sa, input bit with_wr, input logic [7:0] wd);
    bit acc = (model_q.size() > 0);
    bit exp_drop = acc || (model_q.size() >= DEPTH);
    start = 1'b1; dest_addr = da; src_addr = sa;
    wr_en = with_wr; wr_data = wd;
    if (acc) begin
      exp_q.push_back('{da, 1'b0});
      exp_q.push_back('{sa, 1'b0});
      exp_q.push_back('{8'(model_q.size()), 1'b0});
      for (int i = 0; i < model_q.size(); i++)
        exp_q.push_back('{model_q[i], i == model_q.size() - 1});
      model_q.delete();
    end
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    if (with_wr) begin
      chk("start_wr_drop", wr_drop, exp_drop);
      if (!exp_drop) model_q.push_back(wd);
    end
    if (acc) begin
      @(negedge clk);
      chk("da_latency", {data_status, data}, {1'b1, da});
      chk("busy_rise", busy, 1);
    end else begin
      chk("ignored_busy", busy, 0);
    end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy && !data_status && exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    chk("idle_timeout", ok, 1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit ok;
    #12;
    chk("rst_data", data, 0);
    chk("rst_status", data_status, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_drop", wr_drop, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk);

    // Basic 3-byte packet
    write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
    do_start(8'hA5, 8'h5A, 0, 8'h00);
    wait_idle();
    chk("empty_after_pkt1", empty, 1);

    // Fill to DEPTH, one overflow write
    for (int i = 0; i < DEPTH; i++) write_byte(8'(i));
    write_byte(8'hFF);
    do_start(8'h01, 8'h02, 0, 8'h00);
    wait_idle();
    chk("empty_after_full_pkt", empty, 1);

    // Back-to-back packets with pointer wrap
    for (int i = 0; i < 12; i++) write_byte(8'h40 + 8'(i));
    do_start(8'h12, 8'h34, 0, 8'h00);
    wait_idle();
    write_byte(8'h9C);
    do_start(8'h21, 8'h43, 0, 8'h00);
    wait_idle();
    for (int i = 0; i < 4; i++) write_byte(8'hB0 + 8'(i));
    do_start(8'h56, 8'h78, 0, 8'h00);
    wait_idle();

    // start with empty FIFO is ignored
    do_start(8'hDE, 8'hAD, 0, 8'h00);
    repeat (4) begin
      @(negedge clk);
      chk("empty_start_busy", busy, 0);
    end

    // start coinciding with a write: the write is dropped
    write_byte(8'h61); write_byte(8'h62);
    do_start(8'h71, 8'h72, 1, 8'h63);
    wait_idle();

    // Reset during payload byte 2 of a 5-byte packet
    for (int i = 1; i <= 5; i++) write_byte(8'hC0 + 8'(i));
    do_start(8'h10, 8'h20, 0, 8'h00);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (data_status && data == 8'hC2) begin ok = 1; break; end
    end
    chk("reach_pay2", ok, 1);
    #2 rst = 1'b0;
    exp_q.delete();
    model_q.delete();
    #1;
    chk("async_rst_status", data_status, 0);
    chk("async_rst_data", data, 0);
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_empty", empty, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_full", full, 0);
    write_byte(8'h5E);
    do_start(8'hE1, 8'hE2, 0, 8'h00);
    wait_idle();

    // start during SA and GAP ignored; write during PAY dropped
    write_byte(8'h81); write_byte(8'h82); write_byte(8'h83);
    do_start(8'h31, 8'h32, 0, 8'h00);
    start = 1'b1; dest_addr = 8'hEE; src_addr = 8'hEF;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'h77;
    @(negedge clk);
    wr_en = 1'b0;
    chk("pay_wr_drop", wr_drop, 1);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("reach_gap", ok, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    chk("gap_start_ignored_empty", empty, 1);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      int nwr = $urandom_range(0, DEPTH + 2);
      for (int i = 0; i < nwr; i++) write_byte(8'($urandom));
      do_start(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom));
      wait_idle();
      chk("rand_empty", empty, model_q.size() == 0);
    end
    if (model_q.size() > 0) begin
      do_start(8'hAA, 8'hBB, 0, 8'h00);
      wait_idle();
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/switch_pkt_tx.md
Name: switch_pkt_tx

Overview:
- Packet transmitter that drives the input side of the four-port switch: the `data` / `data_status` byte stream.
- A host preloads payload bytes into an internal FIFO, then pulses `start` with destination and source addresses.
- The block serializes the packet as destination address, source address, length byte, then the payload bytes, on consecutive cycles.
- It then forces an inter-packet idle gap before another packet may be sent.

Parameters:
- DEPTH, 16, payload FIFO depth in bytes; legal range 2..255.
- GAP_CYCLES, 2, number of idle cycles with data_status=0 after each packet; legal range ≥1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- wr_en  input  1  write one payload byte into the FIFO.
- wr_data  input  8  payload byte.
- full  output  1  FIFO holds DEPTH bytes.
- empty  output  1  FIFO holds 0 bytes.
- wr_drop  output  1  one-cycle pulse: a write was rejected.
- start  input  1  request transmission of the current FIFO contents.
- dest_addr  input  8  destination address byte, sampled on an accepted start.
- src_addr  input  8  source address byte, sampled on an accepted start.
- busy  output  1  packet or gap in progress.
- done  output  1  one-cycle pulse after the last payload byte.
- data  output  8  byte stream to the switch.
- data_status  output  1  data holds a valid packet byte.

Behaviour:
- Reset (rst=0, asynchronous):
  - data=0, data_status=0, busy=0, done=0, wr_drop=0, full=0, empty=1.
  - FIFO pointers and count cleared; FSM forced to IDLE.
  - A packet in flight is abandoned; data_status drops without waiting for a clock edge.
- Outputs: all registered, no combinational path from inputs to outputs.
- FSM states: IDLE → DA → SA → LEN → PAY → GAP → IDLE.
  - IDLE: start=1 and count≥1 → accepted. Latch dest_addr, src_addr, len=count; go to DA.
    - start with empty FIFO is ignored; no state change, no pulse.
  - DA: data=dest_addr, data_status=1, one cycle.
  - SA: data=src_addr, data_status=1, one cycle.
  - LEN: data=len, data_status=1, one cycle.
  - PAY: pop one byte per cycle and drive it with data_status=1; exactly len cycles; remaining counter decrements each byte.
  - GAP: data=0, data_status=0 for GAP_CYCLES cycles, then IDLE.
- Packet timing:
  - start is accepted at edge N; the DA byte appears after edge N+1.
  - Bytes are strictly contiguous: packet occupies 3+len cycles with no gaps.
  - done pulses with the first GAP cycle.
  - busy=1 from edge N+1 through the last GAP cycle.
  - Next start is accepted at the earliest in the cycle busy is low.
- Length arithmetic:
  - count width is clog2(DEPTH+1).
  - Length byte = count zero-extended to 8 bits.
  - Packets carry 1..DEPTH payload bytes.
- Writes:
  - Accepted only when FSM is IDLE and full=0 and start is not being accepted in the same cycle.
  - Otherwise the byte is discarded and wr_drop pulses.
  - A write coinciding with an accepted start is therefore dropped; the packet length excludes it.
  - A write with full=1 is dropped.
- FIFO:
  - Circular, pointers wrap at DEPTH.
  - full/empty are derived from count and are registered-consistent with count.
- start while busy: ignored, no pulse, no effect on the current packet.
- data holds 0 whenever data_status=0.

Test Plan:
- Reset, write 0x11,0x22,0x33; start with dest=0xA5, src=0x5A → stream A5,5A,03,11,22,33 with data_status=1 for 6 contiguous cycles starting one cycle after start. done pulses next cycle; data_status=0 for 2 cycles; busy then falls.
- Write 16 bytes 0x00..0x0F (DEPTH=16) → full=1; 17th write → wr_drop pulse, count stays 16. start → length byte 0x10; payload 00..0F in order; empty=1 afterward.
- Two back-to-back packets (lengths 1 and 4) with FIFO pointers wrapping past index 15 → second packet payload is correct and in order; ≥2 idle cycles between packets.
- start with empty FIFO → no data_status, busy stays 0. start and wr_en in the same IDLE cycle with 2 bytes queued → length byte 0x02, wr_drop=1.
- Assert rst=0 during PAY byte 2 of a 5-byte packet → data_status=0 and data=0 immediately; after release empty=1, busy=0. A new 1-byte packet then transmits correctly.
- start pulsed during SA and during GAP → ignored; wr_en during PAY → wr_drop pulse, payload unchanged.
